// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// instr_fetch_pkg : shared fetch-stage constants and next-PC select
// Rev 1.0
// ------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int unsigned c_AW  = 8;
  localparam int unsigned c_DW  = 32;
  localparam logic [31:0] c_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_BRANCH  = 2'd0,
    SEL_JUMP    = 2'd1,
    SEL_HOLD    = 2'd2,
    SEL_ADVANCE = 2'd3
  } fetch_sel_e;

  // Redirects outrank stall; a branch outranks a jump. Reset is applied by the flops.
  function automatic fetch_sel_e fetch_sel(input logic branch_taken,
                                           input logic jump,
                                           input logic stall);
    if (branch_taken)  return SEL_BRANCH;
    else if (jump)     return SEL_JUMP;
    else if (stall)    return SEL_HOLD;
    else               return SEL_ADVANCE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ------------------------------------------------------------------
// instr_fetch_if : decode control, instruction memory and IF/ID bundle
// Rev 1.0
// ------------------------------------------------------------------
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int unsigned AW = c_AW,
  parameter int unsigned DW = c_DW
);
  logic          stall;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          jump;
  logic [AW-1:0] jump_target;
  logic [AW-1:0] addr;
  logic [DW-1:0] instruction;
  logic [AW-1:0] pc;
  logic [DW-1:0] if_id_instr;
  logic [AW-1:0] if_id_pc1;
  logic          if_id_valid;

  modport master (
    input  stall, branch_taken, branch_target, jump, jump_target, instruction,
    output addr, pc, if_id_instr, if_id_pc1, if_id_valid
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, jump_target, instruction,
    input  addr, pc, if_id_instr, if_id_pc1, if_id_valid
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_pc_reg.sv
`default_nettype none
// ------------------------------------------------------------------
// instr_fetch_pc_reg : program counter with redirect/stall/increment mux
// Rev 1.0
// ------------------------------------------------------------------
module instr_fetch_pc_reg
  import instr_fetch_pkg::*;
#(
  parameter int unsigned   AW       = c_AW,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          stall,
  input  wire logic          branch_taken,
  input  wire logic [AW-1:0] branch_target,
  input  wire logic          jump,
  input  wire logic [AW-1:0] jump_target,
  output logic      [AW-1:0] pc,
  output logic      [AW-1:0] pc_plus1
);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;

  // Wraps modulo 2^AW by construction.
  assign pc_plus1 = pc_q + AW'(1);
  assign pc       = pc_q;

  always_comb begin
    pc_d = pc_q;
    unique case (fetch_sel(branch_taken, jump, stall))
      SEL_BRANCH:  pc_d = branch_target;
      SEL_JUMP:    pc_d = jump_target;
      SEL_HOLD:    pc_d = pc_q;
      SEL_ADVANCE: pc_d = pc_plus1;
      default:     pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ------------------------------------------------------------------
// instr_fetch : PC, instruction-memory address and IF/ID pipeline register
// Rev 1.0
// ------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned   AW       = c_AW,
  parameter int unsigned   DW       = c_DW,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  wire logic     clk,
  input  wire logic     reset,
  instr_fetch_if.master bus
);

  logic [AW-1:0] pc;
  logic [AW-1:0] pc_plus1;

  logic [DW-1:0] if_id_instr_q, if_id_instr_d;
  logic [AW-1:0] if_id_pc1_q,   if_id_pc1_d;
  logic          if_id_valid_q, if_id_valid_d;

  instr_fetch_pc_reg #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .reset         (reset),
    .stall         (bus.stall),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .pc            (pc),
    .pc_plus1      (pc_plus1)
  );

  // Memory is asynchronous, so the word for the current PC is available this cycle.
  assign bus.addr        = pc;
  assign bus.pc          = pc;
  assign bus.if_id_instr = if_id_instr_q;
  assign bus.if_id_pc1   = if_id_pc1_q;
  assign bus.if_id_valid = if_id_valid_q;

  always_comb begin
    if_id_instr_d = if_id_instr_q;
    if_id_pc1_d   = if_id_pc1_q;
    if_id_valid_d = if_id_valid_q;
    unique case (fetch_sel(bus.branch_taken, bus.jump, bus.stall))
      SEL_BRANCH, SEL_JUMP: begin
        if_id_instr_d = DW'(c_NOP);
        if_id_pc1_d   = '0;
        if_id_valid_d = 1'b0;
      end
      SEL_HOLD: ;
      SEL_ADVANCE: begin
        if_id_instr_d = bus.instruction;
        if_id_pc1_d   = pc_plus1;
        if_id_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_instr_q <= DW'(c_NOP);
      if_id_pc1_q   <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      if_id_instr_q <= if_id_instr_d;
      if_id_pc1_q   <= if_id_pc1_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_instr_fetch : scoreboard bench with a behavioural fetch model
// Rev 1.0
// ------------------------------------------------------------------
module tb_instr_fetch;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
    logic [7:0]  pc1;
    logic        valid;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] mem [256];
  exp_t        q[$];
  int          n_cmp;
  int          n_err;

  // Behavioural model state
  logic [7:0]  m_pc;
  logic [31:0] m_instr;
  logic [7:0]  m_pc1;
  logic        m_valid;

  instr_fetch_if #(.AW(8), .DW(32)) bus ();

  instr_fetch #(
    .AW       (8),
    .DW       (32),
    .RESET_PC (8'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.instruction = mem[bus.addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected snapshot per clock edge, sampled after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc",          {24'h0, bus.pc},          {24'h0, e.pc});
      chk("addr",        {24'h0, bus.addr},        {24'h0, e.pc});
      chk("if_id_instr", bus.if_id_instr,          e.instr);
      chk("if_id_pc1",   {24'h0, bus.if_id_pc1},   {24'h0, e.pc1});
      chk("if_id_valid", {31'h0, bus.if_id_valid}, {31'h0, e.valid});
    end
  end

  task automatic step(input logic r, input logic st, input logic br, input logic [7:0] bt,
                      input logic j, input logic [7:0] jt);
    exp_t e;
    @(negedge clk);
    reset             = r;
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = bt;
    bus.jump          = j;
    bus.jump_target   = jt;
    if (r) begin
      m_pc = 8'd0; m_instr = 32'h0; m_pc1 = 8'd0; m_valid = 1'b0;
    end else if (br || j) begin
      m_pc = br ? bt : jt;
      m_instr = 32'h0; m_pc1 = 8'd0; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = mem[m_pc];
      m_pc1   = 8'((int'(m_pc) + 1) % 256);
      m_valid = 1'b1;
      m_pc    = m_pc1;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc1 = m_pc1; e.valid = m_valid;
    q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.jump = 1'b0;
    bus.branch_target = 8'h0; bus.jump_target = 8'h0;
    m_pc = 8'd0; m_instr = 32'h0; m_pc1 = 8'd0; m_valid = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h20080005;
    mem[1] = 32'h20090003;
    mem[2] = 32'h01095020;
    mem[3] = 32'hAC0A0000;

    // Reset, advance to pc=2, stall three cycles, release, advance to pc=4
    step(1, 0, 0, 8'h00, 0, 8'h00);
    step(0, 0, 0, 8'h00, 0, 8'h00);
    step(0, 0, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 0, 8'h00);
    step(0, 0, 0, 8'h00, 0, 8'h00);
    step(0, 0, 0, 8'h00, 0, 8'h00);
    // Branch at pc=4 to 0x10, then target fetch
    step(0, 0, 1, 8'h10, 0, 8'h00);
    step(0, 0, 0, 8'h00, 0, 8'h00);
    // Branch, jump and stall together
    step(0, 1, 1, 8'h20, 1, 8'h40);
    step(0, 0, 0, 8'h00, 0, 8'h00);
    // Jump alone, then wrap through 0xFF
    step(0, 0, 0, 8'h00, 1, 8'hFF);
    step(0, 0, 0, 8'h00, 0, 8'h00);
    step(0, 0, 0, 8'h00, 0, 8'h00);
    // Reset while stalled at pc=0x22, then fetch from reset PC
    step(0, 0, 0, 8'h00, 1, 8'h22);
    step(0, 1, 0, 8'h00, 0, 8'h00);
    step(1, 1, 1, 8'h55, 1, 8'h66);
    step(0, 0, 0, 8'h00, 0, 8'h00);

    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, 8'($urandom),
           $urandom_range(0, 7) == 0, 8'($urandom));
    step(0, 0, 0, 8'h00, 0, 8'h00);

    #2;
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
